// File: rtl/mux_arb_2_1_pkg.sv
`default_nettype none
// =============================================================================
// Module : mux_arb_2_1_pkg
// Brief  : Shared grant-state encoding and default data width for mux_arb_2_1.
// Rev    : 1.0
// =============================================================================
package mux_arb_2_1_pkg;

  localparam int C_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/MUX_32_2_1.sv
`default_nettype none
// =============================================================================
// Module : MUX_32_2_1
// Brief  : Shared 2:1 datapath multiplexer (s=0 selects a0, s=1 selects a1).
// Rev    : 1.0
// =============================================================================
module MUX_32_2_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? a1 : a0;

endmodule
`default_nettype wire

// File: rtl/mux_arb_2_1.sv
`default_nettype none
// =============================================================================
// Module : mux_arb_2_1
// Brief  : Two-requester burst-limited arbiter driving MUX_32_2_1, with a
//          registered valid/ready output stage.
//          MUX_ARB_RR_EN defined -> round-robin, otherwise fixed priority.
// Rev    : 1.0
// =============================================================================
module mux_arb_2_1
  import mux_arb_2_1_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int                 C_CNT_W     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(BURST - 1);

  state_t             r_state;
  state_t             w_arb;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_s;
  logic               r_y_valid;
  logic [WIDTH-1:0]   r_y;
  logic [C_CNT_W-1:0] r_beat;
  logic               w_load;
  logic               w_ack0;
  logic               w_ack1;
  logic               w_ack;
  logic               w_sel;
  logic               w_cur_req;
  logic               w_last_beat;
  logic               w_rearb;
  logic [WIDTH-1:0]   w_mux_y;

  assign w_load      = !r_y_valid || y_ready;
  assign w_ack0      = r_gnt0 && req0 && w_load;
  assign w_ack1      = r_gnt1 && req1 && w_load;
  assign w_ack       = w_ack0 || w_ack1;
  assign w_sel       = (r_state == GRANT1);
  assign w_cur_req   = (r_state == GRANT0) ? req0 : req1;
  assign w_last_beat = w_ack && (r_beat == C_LAST_BEAT);
  // Re-arbitrate from IDLE, when the owner lets go, or after its final beat.
  assign w_rearb     = (r_state == IDLE) || !w_cur_req || w_last_beat;

`ifdef MUX_ARB_RR_EN
  logic r_last;

  // r_last names the requester granted most recently; the other one wins a tie.
  always_comb begin
    w_arb = IDLE;
    if (req0 && req1) begin
      w_arb = r_last ? GRANT0 : GRANT1;
    end else if (req0) begin
      w_arb = GRANT0;
    end else if (req1) begin
      w_arb = GRANT1;
    end
  end
`else
  always_comb begin
    w_arb = IDLE;
    if (req0) begin
      w_arb = GRANT0;
    end else if (req1) begin
      w_arb = GRANT1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_beat  <= '0;
`ifdef MUX_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else if (w_rearb) begin
      r_state <= w_arb;
      r_gnt0  <= (w_arb == GRANT0);
      r_gnt1  <= (w_arb == GRANT1);
      r_beat  <= '0;
`ifdef MUX_ARB_RR_EN
      if (w_arb != IDLE) begin
        r_last <= (w_arb == GRANT1);
      end
`endif
    end else if (w_ack) begin
      r_beat <= r_beat + C_CNT_W'(1);
    end
  end

  MUX_32_2_1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a0 (a0),
    .a1 (a1),
    .s  (w_sel),
    .y  (w_mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_s       <= 1'b0;
      r_y_valid <= 1'b0;
    end else if (w_ack) begin
      r_y       <= w_mux_y;
      r_s       <= w_sel;
      r_y_valid <= 1'b1;
    end else if (y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign ack0    = w_ack0;
  assign ack1    = w_ack1;
  assign s       = r_s;
  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_2_1.sv
`default_nettype none
// Bench for mux_arb_2_1: randomized requesters, ownership/burst reference model
// and a scoreboard of expected words drained by an independent output monitor.
module tb_mux_arb_2_1;

  localparam int WIDTH = 32;
  localparam int BURST = 4;

  localparam int M_IDLE = 0;
  localparam int M_REQ0 = 1;
  localparam int M_BOTH = 2;
  localparam int M_BP   = 3;
  localparam int M_REQ1 = 4;
  localparam int M_RAND = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, y_ready;
  logic [WIDTH-1:0] a0, a1, y;
  logic             gnt0, gnt1, ack0, ack1, s, y_valid;

  always #5 clk = ~clk;

  mux_arb_2_1 #(
    .WIDTH (WIDTH),
    .BURST (BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .a1      (a1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .ack0    (ack0),
    .ack1    (ack1),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sel;
  } word_t;

  word_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: who owns the datapath, how many beats it has used,
  // who was granted last, and whether the output stage holds a word.
  int               owner;
  int               beats;
  int               last;
  bit               m_valid;
  bit               pend [2];
  bit               req  [2];
  logic [WIDTH-1:0] word [2];
  int               acks [2];
  bit               first = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (req[0] && req[1]) begin
`ifdef MUX_ARB_RR_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_step();
    bit ld;
    bit ack [2];
    bit any;
    int k;
    ld     = !m_valid || y_ready;
    ack[0] = (owner == 0) && req[0] && ld;
    ack[1] = (owner == 1) && req[1] && ld;
    any    = ack[0] || ack[1];
    check("ctrl{gnt0,gnt1,ack0,ack1,y_valid}",
          64'({gnt0, gnt1, ack0, ack1, y_valid}),
          64'({owner == 0, owner == 1, ack[0], ack[1], m_valid}));
    if (any) begin
      k = ack[0] ? 0 : 1;
      sb_q.push_back('{data: word[k], sel: (k == 1)});
      pend[k] = 1'b0;
      acks[k]++;
    end
    if (owner < 0 || !req[owner] || (any && beats == BURST - 1)) begin
      owner = pick();
      beats = 0;
      if (owner >= 0) last = owner;
    end else if (any) begin
      beats++;
    end
    if (any)          m_valid = 1'b1;
    else if (y_ready) m_valid = 1'b0;
  endtask

  task automatic drive(input int mode, input int cyc);
    bit want [2];
    case (mode)
      M_REQ0: begin want[0] = 1'b1; want[1] = 1'b0; y_ready = 1'b1; end
      M_BOTH: begin want[0] = 1'b1; want[1] = 1'b1; y_ready = 1'b1; end
      M_BP: begin
        want[0] = 1'b1; want[1] = 1'b1;
        y_ready = !(cyc >= 4 && cyc < 7);
      end
      M_REQ1: begin want[0] = 1'b0; want[1] = (acks[1] < 2); y_ready = 1'b1; end
      M_RAND: begin
        want[0] = ($urandom_range(0, 3) != 0);
        want[1] = ($urandom_range(0, 3) != 0);
        y_ready = ($urandom_range(0, 3) != 0);
      end
      default: begin want[0] = 1'b0; want[1] = 1'b0; y_ready = 1'b1; end
    endcase
    for (int i = 0; i < 2; i++) begin
      if (!pend[i]) begin
        req[i] = want[i];
        if (want[i]) begin
          pend[i] = 1'b1;
          word[i] = first ? 32'h0000_0001 : $urandom();
          first   = 1'b0;
        end
      end
    end
    req0 = req[0];
    req1 = req[1];
    a0   = word[0];
    a1   = word[1];
  endtask

  task automatic cycle(input int mode, input int cyc, input bit r);
    @(posedge clk);
    #1;
    rst = r;
    drive(mode, cyc);
    @(negedge clk);
    if (rst) begin
      check("reset_outputs", 64'({gnt0, gnt1, ack0, ack1, s, y_valid, y}), 64'd0);
      owner   = -1;
      beats   = 0;
      last    = 1;
      m_valid = 1'b0;
      sb_q.delete();
    end else begin
      model_step();
    end
  endtask

  // Output monitor: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    word_t w;
    if (!rst && y_valid && y_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: actual y=%0h required no word (t=%0t)", y, $time);
      end else begin
        w = sb_q.pop_front();
        check("y_data", 64'(y), 64'(w.data));
        check("y_sel", 64'(s), 64'(w.sel));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    req0    = 1'b0;
    req1    = 1'b0;
    a0      = '0;
    a1      = '0;
    y_ready = 1'b0;
    owner   = -1;
    beats   = 0;
    last    = 1;
    m_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      req[i]  = 1'b0;
      word[i] = '0;
      acks[i] = 0;
    end

    for (int c = 0; c < 2; c++)   cycle(M_IDLE, c, 1'b1);
    for (int c = 0; c < 8; c++)   cycle(M_REQ0, c, 1'b0);
    for (int c = 0; c < 24; c++)  cycle(M_BOTH, c, (c == 14 || c == 15));
    for (int c = 0; c < 14; c++)  cycle(M_BP, c, 1'b0);
    for (int c = 0; c < 6; c++)   cycle(M_IDLE, c, 1'b0);
    acks[0] = 0;
    acks[1] = 0;
    for (int c = 0; c < 12; c++)  cycle(M_REQ1, c, 1'b0);
    for (int c = 0; c < 400; c++) cycle(M_RAND, c, (c == 200));
    for (int c = 0; c < 8; c++)   cycle(M_IDLE, c, 1'b0);

    check("drain_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
